// File: rtl/bin_string_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bin_string_sequencer
// Purpose  : Streams a word as ASCII binary digits, MSB nibble first, with an
//            optional separator character between nibble groups.
// Revision : 1.0 - initial release
// ============================================================================
module bin_string_sequencer #(
  parameter int         NIBBLES  = 4,
  parameter bit         SEP_EN   = 1'b1,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   word,
  output logic [3:0]             nib,
  input  logic [31:0]            bit_ascii,
  output logic [7:0]             char_out,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_EMIT   = 2'd1;
  localparam logic [1:0] C_SEP    = 2'd2;
  localparam logic [1:0] C_FINISH = 2'd3;

  logic [1:0]             r_state;
  logic [4*NIBBLES-1:0]   r_word;
  logic [2:0]             r_nib_idx;
  logic [1:0]             r_bit_idx;

  logic                   w_xfer;
  logic [4*NIBBLES-1:0]   w_word_shift;
  logic [3:0]             w_nib_sel;
  logic [7:0]             w_bit_char;

  assign w_xfer       = char_valid && char_ready;
  assign w_word_shift = r_word >> {r_nib_idx, 2'b00};
  assign w_nib_sel    = w_word_shift[3:0];

  always_comb begin
    case (r_bit_idx)
      2'd0:    w_bit_char = bit_ascii[31:24];
      2'd1:    w_bit_char = bit_ascii[23:16];
      2'd2:    w_bit_char = bit_ascii[15:8];
      default: w_bit_char = bit_ascii[7:0];
    endcase
  end

  // Outputs decode from state only, so reset clears them without waiting on a clock.
  always_comb begin
    nib        = 4'h0;
    char_out   = 8'h00;
    char_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      C_EMIT: begin
        nib        = w_nib_sel;
        char_out   = w_bit_char;
        char_valid = 1'b1;
        busy       = 1'b1;
      end
      C_SEP: begin
        nib        = w_nib_sel;
        char_out   = SEP_CHAR;
        char_valid = 1'b1;
        busy       = 1'b1;
      end
      C_FINISH: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= C_IDLE;
      r_word    <= '0;
      r_nib_idx <= 3'd0;
      r_bit_idx <= 2'd0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (start) begin
            r_word    <= word;
            r_nib_idx <= 3'(NIBBLES - 1);
            r_bit_idx <= 2'd0;
            r_state   <= C_EMIT;
          end
        end
        C_EMIT: begin
          if (w_xfer) begin
            if (r_bit_idx != 2'd3) begin
              r_bit_idx <= r_bit_idx + 2'd1;
            end else if (r_nib_idx != 3'd0) begin
              r_bit_idx <= 2'd0;
              r_nib_idx <= r_nib_idx - 3'd1;
              r_state   <= SEP_EN ? C_SEP : C_EMIT;
            end else begin
              r_state <= C_FINISH;
            end
          end
        end
        C_SEP: begin
          if (w_xfer) begin
            r_state <= C_EMIT;
          end
        end
        C_FINISH: begin
          r_nib_idx <= 3'd0;
          r_bit_idx <= 2'd0;
          r_state   <= C_IDLE;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_string_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_string_sequencer
// Purpose  : Directed scoreboard bench for bin_string_sequencer (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_string_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_s [3];
  logic [15:0] word_s  [3];
  logic        ready_s [3];
  logic [3:0]  nib_s   [3];
  logic [31:0] ba_s    [3];
  logic [7:0]  cout_s  [3];
  logic        cval_s  [3];
  logic        busy_s  [3];
  logic        done_s  [3];

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  q[$];

  always #5 clk = ~clk;

  // Reference hex-to-bit-ASCII converter feeding each instance.
  function automatic logic [31:0] conv(input logic [3:0] n);
    return {7'h18, n[3], 7'h18, n[2], 7'h18, n[1], 7'h18, n[0]};
  endfunction

  assign ba_s[0] = conv(nib_s[0]);
  assign ba_s[1] = conv(nib_s[1]);
  assign ba_s[2] = conv(nib_s[2]);

  bin_string_sequencer #(.NIBBLES(4), .SEP_EN(1'b1), .SEP_CHAR(8'h20)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .word(word_s[0]),
    .nib(nib_s[0]), .bit_ascii(ba_s[0]), .char_out(cout_s[0]), .char_valid(cval_s[0]),
    .char_ready(ready_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  bin_string_sequencer #(.NIBBLES(2), .SEP_EN(1'b0), .SEP_CHAR(8'h20)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .word(word_s[1][7:0]),
    .nib(nib_s[1]), .bit_ascii(ba_s[1]), .char_out(cout_s[1]), .char_valid(cval_s[1]),
    .char_ready(ready_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  bin_string_sequencer #(.NIBBLES(1), .SEP_EN(1'b1), .SEP_CHAR(8'h20)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_s[2]), .word(word_s[2][3:0]),
    .nib(nib_s[2]), .bit_ascii(ba_s[2]), .char_out(cout_s[2]), .char_valid(cval_s[2]),
    .char_ready(ready_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, "_valid"}, 32'(cval_s[k]), 32'd0);
    chk({tag, "_char"},  32'(cout_s[k]), 32'd0);
    chk({tag, "_busy"},  32'(busy_s[k]), 32'd0);
    chk({tag, "_done"},  32'(done_s[k]), 32'd0);
    chk({tag, "_nib"},   32'(nib_s[k]),  32'd0);
  endtask

  // mode: 0 ready held high, 1 ready toggles, 2 restart attempt mid-word, 3 reset after 7th transfer
  task automatic run(input int k, input logic [15:0] w, input int mode);
    int         n, sep, cyc, xfers;
    bit         prev_stall;
    logic [7:0] prev;
    n   = (k == 0) ? 4 : (k == 1) ? 2 : 1;
    sep = (k == 0) ? 1 : 0;
    q.delete();
    for (int i = n - 1; i >= 0; i--) begin
      for (int b = 3; b >= 0; b--) q.push_back(w[4*i+b] ? 8'h31 : 8'h30);
      if (i > 0 && sep == 1) q.push_back(8'h20);
    end
    @(negedge clk);
    start_s[k] = 1'b1;
    word_s[k]  = w;
    ready_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    if (mode == 2) word_s[k] = 16'hFFFF;
    cyc = 1; xfers = 0; prev_stall = 1'b0; prev = 8'h00;
    while (cyc < 200 && q.size() != 0) begin
      if (mode == 1) ready_s[k] = (cyc % 2 == 1);
      start_s[k] = (mode == 2 && (cyc == 5 || cyc == 6));
      chk("valid", 32'(cval_s[k]), 32'd1);
      chk("busy",  32'(busy_s[k]), 32'd1);
      if (prev_stall) chk("hold", 32'(cout_s[k]), 32'(prev));
      if (ready_s[k]) begin
        chk("char", 32'(cout_s[k]), 32'(q.pop_front()));
        xfers++;
        if (mode == 3 && xfers == 7) begin
          @(posedge clk);
          #2 reset_n = 1'b0;
          #1 chk_idle(k, "rst_mid");
          @(negedge clk);
          reset_n = 1'b1;
          q.delete();
          for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle(k, "post_rst");
          end
          return;
        end
      end
      prev_stall = !ready_s[k];
      prev       = cout_s[k];
      @(negedge clk);
      cyc++;
    end
    start_s[k] = 1'b0;
    ready_s[k] = 1'b1;
    if (q.size() != 0) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    chk("done",       32'(done_s[k]), 32'd1);
    chk("done_busy",  32'(busy_s[k]), 32'd0);
    chk("done_valid", 32'(cval_s[k]), 32'd0);
    if (mode != 1) chk("done_cycle", 32'(cyc), 32'(4*n + sep*(n-1) + 1));
    @(negedge clk);
    chk_idle(k, "after_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      word_s[k]  = 16'h0000;
      ready_s[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle(k, "reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle(0, "idle");

    run(0, 16'hA5C3, 0);
    run(0, 16'h000F, 1);
    run(0, 16'h1234, 2);
    run(0, 16'hA5C3, 3);
    run(0, 16'h0001, 0);
    run(1, 16'h005A, 0);
    run(2, 16'h0009, 0);
    run(1, 16'h00C3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_string_sequencer.md
BIN_STRING_SEQUENCER -- requirements
Module: bin_string_sequencer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning number of 4-bit nibbles per word (range 1..8).
REQ-002 SHALL have parameter SEP_EN, default 1, meaning 1 inserts a separator character between nibble groups.
REQ-003 SHALL have parameter SEP_CHAR, default 8'h20, meaning the ASCII separator byte (space).
REQ-004 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have start  input  1  request to convert word; sampled only in IDLE.
REQ-007 SHALL have word  input  4*NIBBLES  value to convert, captured on accepted start.
REQ-008 SHALL have nib  output  4  nibble driven to the external hex-to-bit-ASCII converter.
REQ-009 SHALL have bit_ascii  input  32  converter result, 4 ASCII '0'/'1' chars, MSB char in [31:24].
REQ-010 SHALL have char_out  output  8  current ASCII character.
REQ-011 SHALL have char_valid  output  1  char_out holds a valid character.
REQ-012 SHALL have char_ready  input  1  downstream accepts char_out this cycle.
REQ-013 SHALL have busy  output  1  high from accepted start until after the last transfer.
REQ-014 SHALL have done  output  1  one-cycle pulse after last character accepted.

Function
REQ-015 SHALL implement FSM states IDLE, EMIT, SEP, FINISH.
REQ-016 IDLE: start=1 -> latch word, nibble index = NIBBLES-1, bit index = 0, go EMIT; start=0 -> stay.
REQ-017 nib SHALL be the latched nibble at current nibble index (MSB nibble first); nib = 0 in IDLE.
REQ-018 EMIT: char_out SHALL be bit_ascii byte selected by bit index (0 -> [31:24], 3 -> [7:0]); char_valid = 1.
REQ-019 Transfer occurs when char_valid && char_ready on a rising edge; without transfer char_out, nib, state SHALL hold.
REQ-020 EMIT transfer with bit index < 3 -> bit index + 1.
REQ-021 EMIT transfer with bit index = 3 and nibble index > 0 -> bit index = 0, nibble index - 1, go SEP if SEP_EN else stay EMIT.
REQ-022 EMIT transfer with bit index = 3 and nibble index = 0 -> go FINISH.
REQ-023 SEP: char_out = SEP_CHAR, char_valid = 1; transfer -> go EMIT.
REQ-024 FINISH: char_valid = 0, done = 1 for exactly one cycle, busy = 0, next state IDLE.
REQ-025 busy SHALL be 1 in EMIT and SEP, 0 in IDLE and FINISH.
REQ-026 Latency: start accepted at edge N -> first character valid in cycle after edge N; with char_ready held 1, done high 4*NIBBLES + SEP_EN*(NIBBLES-1) cycles after first valid.
REQ-027 start while busy SHALL be ignored; word changes while busy SHALL not affect output.
REQ-028 char_valid SHALL never drop without a transfer once asserted (no retraction).
REQ-029 NIBBLES = 1 SHALL emit no separator regardless of SEP_EN.

Reset
REQ-030 reset_n = 0 SHALL asynchronously force IDLE, char_valid = 0, char_out = 8'h00, nib = 4'h0, busy = 0, done = 0, indices = 0.
REQ-031 Reset mid-conversion SHALL abandon the word; no done pulse; first cycle after release is IDLE.

Verification
REQ-032 word = 16'hA5C3, char_ready = 1 -> chars "1010 0101 1100 0011" (19 bytes, 8'h31/8'h30/8'h20) on 19 consecutive cycles, done on cycle 20.
REQ-033 word = 16'h000F, char_ready toggled 1/0 every cycle -> same byte sequence "0000 0000 0000 1111", each byte held stable while char_ready = 0.
REQ-034 start pulsed again with word = 16'hFFFF during conversion of 16'h1234 -> output remains "0001 0010 0011 0100", single done.
REQ-035 reset_n low after 7th transfer of 16'hA5C3 -> outputs zero immediately; no done; next start with 16'h0001 -> "0000 0000 0000 0001".
REQ-036 SEP_EN = 0, NIBBLES = 2, word = 8'h5A -> "01011010" (8 bytes), done on cycle 9.
REQ-037 NIBBLES = 1, word = 4'h9 -> "1001", no separator, done on cycle 5.
